// File: rtl/utils_pkg.sv
// Shared types and helpers for the systolic array feeder.
// The feeder FSM states and the drain-length rule live here so every file uses the same encoding.
package utils_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_e;

   // Cycles for the last injected value to cross the full array diagonal.
   function automatic int drain_len(input int w, input int h);
      return w + h - 1;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-row shift register that builds the diagonal skew on the array's left edge.
// DEPTH=0 is a pure wire so row 0 sees only the shared input stage.
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = clk ^ rst;
         assign dout        = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe_reg [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) pipe_reg[i] <= '0;
            end else begin
               pipe_reg[0] <= din;
               for (int i = 1; i < DEPTH; i++) pipe_reg[i] <= pipe_reg[i-1];
            end
         end

         assign dout = pipe_reg[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_array_feeder.sv
// Input-side sequencer for one PE-array tile job: weight load, skewed activations, drain, pop.
// Optional macro FEEDER_STALL_CNT_EN adds o_stall_cnt counting input-starved cycles.
module systolic_array_feeder
   import utils_pkg::*;
#(
   parameter int PE_ARRAY_W     = 4,
   parameter int PE_ARRAY_H     = 4,
   parameter int IN_DATA_WIDTH  = 8,
   parameter int OUT_DATA_WIDTH = 24,
   parameter int MAX_VEC        = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start,
   input  logic [$clog2(MAX_VEC+1)-1:0]      i_num_vec,
   input  logic                              i_w_vld,
   output logic                              o_w_rdy,
   input  logic [IN_DATA_WIDTH-1:0]          i_w_data    [PE_ARRAY_W],
   input  logic                              i_a_vld,
   output logic                              o_a_rdy,
   input  logic [IN_DATA_WIDTH-1:0]          i_a_data    [PE_ARRAY_H],
   output logic [PE_ARRAY_W-1:0]             o_load_vld,
   output logic [$clog2(PE_ARRAY_H)-1:0]     o_load_id   [PE_ARRAY_W],
   output logic [IN_DATA_WIDTH-1:0]          o_load_data [PE_ARRAY_W],
   output logic [PE_ARRAY_W-1:0]             o_pop_vld,
   output logic [OUT_DATA_WIDTH-1:0]         o_up_data   [PE_ARRAY_W],
   output logic [IN_DATA_WIDTH-1:0]          o_left_data [PE_ARRAY_H],
   output logic                              o_busy,
`ifdef FEEDER_STALL_CNT_EN
   output logic [31:0]                       o_stall_cnt,
`endif
   output logic                              o_done
);

   localparam int VEC_W     = $clog2(MAX_VEC + 1);
   localparam int ID_W      = $clog2(PE_ARRAY_H);
   localparam int DRAIN_LEN = drain_len(PE_ARRAY_W, PE_ARRAY_H);
   localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);

   localparam logic [ID_W-1:0]   LAST_ROW   = ID_W'(PE_ARRAY_H - 1);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_LEN);

   feeder_state_e state_reg, state_next;

   logic [VEC_W-1:0]  k_reg;
   logic [VEC_W-1:0]  vec_cnt_reg;
   logic [ID_W-1:0]   row_cnt_reg;
   logic [DCNT_W-1:0] drain_cnt_reg;

   logic w_rdy, a_rdy, pop;
   logic w_hs, a_hs, start_acc;

   logic                     load_vld_reg;
   logic [ID_W-1:0]          load_id_reg;
   logic [IN_DATA_WIDTH-1:0] load_data_reg [PE_ARRAY_W];
   logic [IN_DATA_WIDTH-1:0] a_stage_reg   [PE_ARRAY_H];

   assign w_hs      = w_rdy & i_w_vld;
   assign a_hs      = a_rdy & i_a_vld;
   assign start_acc = (state_reg == IDLE) & i_start;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      w_rdy      = 1'b0;
      a_rdy      = 1'b0;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) state_next = LOAD;
         end
         LOAD: begin
            w_rdy = 1'b1;
            if (i_w_vld && row_cnt_reg == LAST_ROW)
               state_next = (k_reg != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            a_rdy = (vec_cnt_reg < k_reg);
            // Leave on the edge that accepts the K-th vector so the drain starts right behind it.
            if (vec_cnt_reg == k_reg ||
                (a_rdy && i_a_vld && (vec_cnt_reg + VEC_W'(1)) == k_reg))
               state_next = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt_reg == DRAIN_LAST) begin
               pop        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_reg         <= '0;
         vec_cnt_reg   <= '0;
         row_cnt_reg   <= '0;
         drain_cnt_reg <= '0;
      end else begin
         if (start_acc) begin
            k_reg       <= i_num_vec;
            vec_cnt_reg <= '0;
            row_cnt_reg <= '0;
         end
         if (w_hs && row_cnt_reg != LAST_ROW) row_cnt_reg <= row_cnt_reg + ID_W'(1);
         if (a_hs && vec_cnt_reg != k_reg)    vec_cnt_reg <= vec_cnt_reg + VEC_W'(1);
         if (state_reg != DRAIN)              drain_cnt_reg <= '0;
         else if (drain_cnt_reg != DRAIN_LAST) drain_cnt_reg <= drain_cnt_reg + DCNT_W'(1);
      end
   end

   // Weight beats are re-registered so the array sees one clean beat per accepted row.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_vld_reg <= 1'b0;
         load_id_reg  <= '0;
         for (int j = 0; j < PE_ARRAY_W; j++) load_data_reg[j] <= '0;
      end else begin
         load_vld_reg <= w_hs;
         load_id_reg  <= w_hs ? row_cnt_reg : '0;
         for (int j = 0; j < PE_ARRAY_W; j++)
            load_data_reg[j] <= w_hs ? i_w_data[j] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PE_ARRAY_H; i++) a_stage_reg[i] <= '0;
      end else begin
         for (int i = 0; i < PE_ARRAY_H; i++)
            a_stage_reg[i] <= a_hs ? i_a_data[i] : '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PE_ARRAY_W; gi++) begin : g_col
         assign o_load_id[gi]   = load_id_reg;
         assign o_load_data[gi] = load_data_reg[gi];
         assign o_up_data[gi]   = '0;
      end
      for (gi = 0; gi < PE_ARRAY_H; gi++) begin : g_row
         skew_delay_line #(
            .DEPTH (gi),
            .WIDTH (IN_DATA_WIDTH)
         ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (a_stage_reg[gi]),
            .dout (o_left_data[gi])
         );
      end
   endgenerate

   assign o_load_vld = {PE_ARRAY_W{load_vld_reg}};
   assign o_pop_vld  = {PE_ARRAY_W{pop}};
   assign o_w_rdy    = w_rdy;
   assign o_a_rdy    = a_rdy;
   assign o_busy     = (state_reg != IDLE);
   assign o_done     = pop;

`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic        stall_evt;

   assign stall_evt = ((state_reg == LOAD) & ~i_w_vld) | (a_rdy & ~i_a_vld);

   always_ff @(posedge clk) begin
      if (rst)                                  stall_cnt_reg <= '0;
      else if (start_acc)                       stall_cnt_reg <= '0;
      else if (stall_evt && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed bench for systolic_array_feeder with a cycle-stamped scoreboard checked every negedge.
// Handshakes seen by the monitor push expected load beats, left-edge values and pop cycles.
module tb_systolic_array_feeder;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int DRAIN = W + H - 1;

   typedef logic [7:0] row_t [4];
   typedef struct {
      int          c;
      logic [1:0]  id;
      logic [31:0] d;
   } load_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [8:0]  i_num_vec;
   logic        i_w_vld, o_w_rdy;
   logic [7:0]  i_w_data [W];
   logic        i_a_vld, o_a_rdy;
   logic [7:0]  i_a_data [H];
   logic [W-1:0] o_load_vld;
   logic [1:0]  o_load_id [W];
   logic [7:0]  o_load_data [W];
   logic [W-1:0] o_pop_vld;
   logic [23:0] o_up_data [W];
   logic [7:0]  o_left_data [H];
   logic        o_busy, o_done;
`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] o_stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit mon_en = 0;
   int mon_k, mon_wb, mon_vc;

   load_exp_t   load_q [$];
   int          pop_q  [$];
   logic [31:0] left_sb [int];

   systolic_array_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_num_vec   (i_num_vec),
      .i_w_vld     (i_w_vld),
      .o_w_rdy     (o_w_rdy),
      .i_w_data    (i_w_data),
      .i_a_vld     (i_a_vld),
      .o_a_rdy     (o_a_rdy),
      .i_a_data    (i_a_data),
      .o_load_vld  (o_load_vld),
      .o_load_id   (o_load_id),
      .o_load_data (o_load_data),
      .o_pop_vld   (o_pop_vld),
      .o_up_data   (o_up_data),
      .o_left_data (o_left_data),
      .o_busy      (o_busy),
`ifdef FEEDER_STALL_CNT_EN
      .o_stall_cnt (o_stall_cnt),
`endif
      .o_done      (o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard: compare what is due this cycle, then record what the coming edge will produce.
   logic [31:0] m_exp, m_obs, m_tmp;
   logic [7:0]  m_ids;
   bit          m_pop;
   load_exp_t   m_le;
   always @(negedge clk) begin
      if (mon_en) begin
         if (load_q.size() != 0 && load_q[0].c == cyc) begin
            m_le = load_q.pop_front();
            for (int j = 0; j < W; j++) begin
               m_obs[8*j +: 8] = o_load_data[j];
               m_ids[2*j +: 2] = o_load_id[j];
            end
            chk("load_vld", 64'(o_load_vld), 64'({W{1'b1}}));
            chk("load_id", 64'(m_ids), 64'({W{m_le.id}}));
            chk("load_data", 64'(m_obs), 64'(m_le.d));
         end else begin
            chk("load_vld_idle", 64'(o_load_vld), 64'(0));
         end

         m_exp = left_sb.exists(cyc) ? left_sb[cyc] : 32'd0;
         if (left_sb.exists(cyc)) left_sb.delete(cyc);
         for (int i = 0; i < H; i++)
            chk($sformatf("left%0d", i), 64'(o_left_data[i]), 64'(m_exp[8*i +: 8]));

         m_pop = 1'b0;
         if (pop_q.size() != 0 && pop_q[0] == cyc) begin
            m_pop = 1'b1;
            void'(pop_q.pop_front());
         end
         chk("pop_vld", 64'(o_pop_vld), 64'({W{m_pop}}));
         chk("done", 64'(o_done), 64'(m_pop));
         chk("up_data", 64'(o_up_data[0] | o_up_data[1] | o_up_data[2] | o_up_data[3]), 64'(0));

         if (rst) begin
            load_q.delete();
            pop_q.delete();
            left_sb.delete();
         end else begin
            if (o_w_rdy && i_w_vld) begin
               for (int j = 0; j < W; j++) m_le.d[8*j +: 8] = i_w_data[j];
               m_le.c  = cyc + 1;
               m_le.id = mon_wb[1:0];
               load_q.push_back(m_le);
               mon_wb++;
               if (mon_wb == H && mon_k == 0) pop_q.push_back(cyc + 1 + DRAIN);
            end
            if (o_a_rdy && i_a_vld) begin
               for (int i = 0; i < H; i++) begin
                  m_tmp = left_sb.exists(cyc + 1 + i) ? left_sb[cyc + 1 + i] : 32'd0;
                  m_tmp[8*i +: 8] = i_a_data[i];
                  left_sb[cyc + 1 + i] = m_tmp;
               end
               mon_vc++;
               if (mon_vc == mon_k) pop_q.push_back(cyc + 1 + DRAIN);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int k);
      mon_k     = k;
      mon_wb    = 0;
      mon_vc    = 0;
      i_start   = 1'b1;
      i_num_vec = 9'(k);
      step(1);
      i_start   = 1'b0;
   endtask

   task automatic send_w(input row_t v);
      i_w_vld  = 1'b1;
      i_w_data = v;
      for (int t = 0; t < 50; t++) begin
         if (o_w_rdy) begin
            step(1);
            i_w_vld = 1'b0;
            return;
         end
         step(1);
      end
      i_w_vld = 1'b0;
      chk("w_timeout", 64'(0), 64'(1));
   endtask

   task automatic send_a(input row_t v);
      i_a_vld  = 1'b1;
      i_a_data = v;
      for (int t = 0; t < 50; t++) begin
         if (o_a_rdy) begin
            step(1);
            i_a_vld = 1'b0;
            return;
         end
         step(1);
      end
      i_a_vld = 1'b0;
      chk("a_timeout", 64'(0), 64'(1));
   endtask

   task automatic load_weights(input int base);
      row_t v;
      for (int r = 0; r < H; r++) begin
         for (int j = 0; j < W; j++) v[j] = 8'(base + j + 4 * r);
         send_w(v);
      end
   endtask

   // Returns positioned in the o_done cycle (#1 after its edge).
   task automatic wait_done();
      for (int t = 0; t < 100; t++) begin
         if (o_done) return;
         step(1);
      end
      chk("done_timeout", 64'(0), 64'(1));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t v;
      rst       = 1'b1;
      i_start   = 1'b0;
      i_num_vec = '0;
      i_w_vld   = 1'b0;
      i_a_vld   = 1'b0;
      for (int j = 0; j < W; j++) i_w_data[j] = '0;
      for (int i = 0; i < H; i++) i_a_data[i] = '0;
      step(3);

      // Reset state
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_w_rdy", 64'(o_w_rdy), 64'(0));
      chk("rst_a_rdy", 64'(o_a_rdy), 64'(0));
      chk("rst_load_vld", 64'(o_load_vld), 64'(0));
      chk("rst_pop", 64'(o_pop_vld), 64'(0));
      chk("rst_left3", 64'(o_left_data[3]), 64'(0));
      rst    = 1'b0;
      mon_en = 1'b1;
      step(2);

      // Weight load only, K=0, data j+4r
      start_job(0);
      chk("t1_busy", 64'(o_busy), 64'(1));
      chk("t1_w_rdy", 64'(o_w_rdy), 64'(1));
      chk("t1_a_rdy", 64'(o_a_rdy), 64'(0));
      load_weights(0);
      chk("t1_w_rdy_drain", 64'(o_w_rdy), 64'(0));
      wait_done();
      step(1);
      chk("t1_idle", 64'(o_busy), 64'(0));

      // Skew, K=3 continuous valid
      start_job(3);
      load_weights(16);
      chk("t2_a_rdy", 64'(o_a_rdy), 64'(1));
      v = '{8'd1, 8'd2, 8'd3, 8'd4};     send_a(v);
      v = '{8'd5, 8'd6, 8'd7, 8'd8};     send_a(v);
      v = '{8'd9, 8'd10, 8'd11, 8'd12};  send_a(v);
      chk("t2_a_rdy_after", 64'(o_a_rdy), 64'(0));
      wait_done();
      step(1);

      // Bubble between two vectors, K=2
      start_job(2);
      load_weights(32);
      v = '{8'h11, 8'h22, 8'h33, 8'h44}; send_a(v);
      step(1);
      v = '{8'h55, 8'h66, 8'h77, 8'h88}; send_a(v);
      wait_done();
      step(1);

      // Weight backpressure: 5-cycle gap after two beats
      start_job(0);
      v = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; send_w(v);
      v = '{8'hB0, 8'hB1, 8'hB2, 8'hB3}; send_w(v);
      step(5);
      chk("t4_gap_vld", 64'(o_load_vld), 64'(0));
      v = '{8'hC0, 8'hC1, 8'hC2, 8'hC3}; send_w(v);
      chk("t4_id_resume", 64'(o_load_id[0]), 64'(2));
      v = '{8'hD0, 8'hD1, 8'hD2, 8'hD3}; send_w(v);
      wait_done();
`ifdef FEEDER_STALL_CNT_EN
      chk("t4_stall_cnt", 64'(o_stall_cnt), 64'(5));
`endif
      step(1);

      // Reset mid-STREAM after the second vector
      start_job(4);
      load_weights(48);
      v = '{8'h01, 8'h02, 8'h03, 8'h04}; send_a(v);
      v = '{8'h05, 8'h06, 8'h07, 8'h08}; send_a(v);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("t5_busy", 64'(o_busy), 64'(0));
      chk("t5_a_rdy", 64'(o_a_rdy), 64'(0));
      chk("t5_left1", 64'(o_left_data[1]), 64'(0));
      chk("t5_left3", 64'(o_left_data[3]), 64'(0));
      chk("t5_done", 64'(o_done), 64'(0));
      step(12);
      chk("t5_still_idle", 64'(o_busy), 64'(0));
      start_job(1);
      load_weights(64);
      v = '{8'hF1, 8'hF2, 8'hF3, 8'hF4}; send_a(v);
      wait_done();
      step(1);

      // Start while busy, and start coincident with o_done
      start_job(2);
      i_start   = 1'b1;
      i_num_vec = 9'd0;
      step(1);
      i_start   = 1'b0;
      load_weights(80);
      chk("t6_k_kept", 64'(o_a_rdy), 64'(1));
      v = '{8'h21, 8'h22, 8'h23, 8'h24}; send_a(v);
      v = '{8'h31, 8'h32, 8'h33, 8'h34}; send_a(v);
      wait_done();
      i_start   = 1'b1;
      i_num_vec = 9'd5;
      step(1);
      i_start   = 1'b0;
      chk("t6_start_ignored", 64'(o_busy), 64'(0));
      chk("t6_no_load", 64'(o_w_rdy), 64'(0));
      start_job(0);
      chk("t6_restart", 64'(o_busy), 64'(1));
      load_weights(96);
      wait_done();
      step(3);

      chk("sb_load_empty", 64'(load_q.size()), 64'(0));
      chk("sb_pop_empty", 64'(pop_q.size()), 64'(0));
      chk("sb_left_empty", 64'(left_sb.num()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/systolic_array_feeder.md
Name: systolic_array_feeder

Overview:
- Drives the input side of the systolic PE array for one tile job.
- Accepts a weight tile and activation vectors over valid/ready streams.
- Emits per-column weight-load beats (vld/id/data), diagonally skewed left-edge activations, zero top-edge partial sums and a final pop strobe.
- Sits between the tile buffer/DMA and the PE array; one job per i_start.

Parameters:
- PE_ARRAY_W, 4, array columns
- PE_ARRAY_H, 4, array rows
- IN_DATA_WIDTH, 8, weight/activation width
- OUT_DATA_WIDTH, 24, partial-sum width
- MAX_VEC, 256, max activation vectors per job

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_start  in  1  job start pulse; ignored while o_busy
- i_num_vec  in  $clog2(MAX_VEC+1)  activation vector count K, sampled with i_start; 0 means weight load and pop only
- i_w_vld  in  1  weight row beat valid
- o_w_rdy  out  1  weight row beat ready
- i_w_data  in  IN_DATA_WIDTH x PE_ARRAY_W (unpacked)  one weight row, element j to column j
- i_a_vld  in  1  activation vector valid
- o_a_rdy  out  1  activation vector ready
- i_a_data  in  IN_DATA_WIDTH x PE_ARRAY_H (unpacked)  one activation vector, element i to row i
- o_load_vld  out  1 x PE_ARRAY_W  to array i_load_vld
- o_load_id  out  $clog2(PE_ARRAY_H) x PE_ARRAY_W  to array i_load_id
- o_load_data  out  IN_DATA_WIDTH x PE_ARRAY_W  to array i_load_data
- o_pop_vld  out  1 x PE_ARRAY_W  to array i_pop_vld
- o_up_data  out  OUT_DATA_WIDTH x PE_ARRAY_W  to array i_up_data; constant 0
- o_left_data  out  IN_DATA_WIDTH x PE_ARRAY_H  to array i_left_data
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: FSM=IDLE. All outputs 0; skew pipes cleared; counters 0.
- FSM states:
  - IDLE: o_busy=0. i_start goes to LOAD, latches K and clears row_cnt.
  - LOAD: o_w_rdy=1. Each handshake drives, in the next cycle, o_load_vld[j]=1, o_load_id[j]=row_cnt and o_load_data[j]=i_w_data[j] on all columns, then row_cnt++. After PE_ARRAY_H beats, go to STREAM (K>0) or DRAIN (K=0). Without a handshake, o_load_vld=0.
  - STREAM: o_a_rdy=1 while vec_cnt<K. An accepted vector enters skew stage 0. Row i appears on o_left_data[i] exactly 1+i cycles after the handshake. Bubbles (no handshake) inject 0 into the skew pipe. At vec_cnt==K, go to DRAIN.
  - DRAIN: waits PE_ARRAY_H+PE_ARRAY_W-1 cycles with zero injection. Then it asserts o_pop_vld on all columns for exactly one cycle, pulses o_done in the same cycle, and returns to IDLE.
- o_busy=1 in LOAD/STREAM/DRAIN.
- o_w_rdy=0 outside LOAD; o_a_rdy=0 outside STREAM.
- Counters: row_cnt wraps never (bounded by PE_ARRAY_H); vec_cnt saturates at K.
- Back-to-back: i_start in the same cycle as o_done is ignored; the earliest accepted start is the cycle after o_done.
- rst mid-job: immediate return to IDLE, skew pipe flushed, no o_done, no pop.
- Data passes unmodified (no arithmetic). o_up_data is tied 0.

Optional Feature:
- FEEDER_STALL_CNT_EN
- Defined: adds output o_stall_cnt[31:0]. It counts cycles in LOAD with !i_w_vld plus cycles in STREAM with o_a_rdy && !i_a_vld. Cleared on i_start acceptance and on rst; saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- utils_pkg gets:
  - typedef feeder_state_e {IDLE, LOAD, STREAM, DRAIN}
  - function drain_len(W,H)=W+H-1
- Sub-module skew_delay_line (parameters DEPTH, WIDTH) implements the per-row shift register, instanced PE_ARRAY_H times with DEPTH=i.

Test Plan:
- Weight load, 4x4: i_start, K=0, 4 weight beats with data j+4r. Required: o_load_id sequence 0,1,2,3, data matching on each column; pop once after 7 drain cycles; o_done coincident with pop.
- Skew: K=3 vectors {1,2,3,4},{5,6,7,8},{9,10,11,12}, continuous valid. Required: o_left_data[0] shows 1,5,9 at cycles t+1..t+3; o_left_data[3] shows 4,8,12 at t+4..t+6; zeros elsewhere.
- Bubbles: i_a_vld toggled 1,0,1 with K=2. Required: a zero inserted between vectors on every row, with per-row skew preserved.
- Weight backpressure: i_w_vld low for 5 cycles mid-load. Required: no o_load_vld during the gap; row_cnt continues at 2 afterwards; stall count is 5 when FEEDER_STALL_CNT_EN.
- Reset mid-STREAM: rst after the 2nd vector. Required: all outputs 0 next cycle, no o_done or pop, and a new job then runs cleanly.
- i_start while busy and coincident with o_done. Required: ignored; K is not relatched.
